// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with a memory-wait watchdog FSM.
// Optional stall_if cycle counter is enabled by defining PIPE_STALL_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_br_taken,
  input  logic        mem_access,
  input  logic        dmem_ready,
  input  logic        imem_ready,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        stall_mem,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        dmem_req,
  output logic        wait_err,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, DWAIT, IWAIT, ERR} state_t;

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cntInc;
  logic             dmemWait;
  logic             loadUse;

  assign dmemWait = mem_access & ~dmem_ready;
  assign loadUse  = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));
  assign cntInc   = (cnt_q == TimeoutVal) ? cnt_q : cnt_q + 1'b1;

  // The counter holds the number of completed wait cycles, so ERR follows
  // exactly TIMEOUT cycles spent in DWAIT/IWAIT with ready still low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        cnt_d = '0;
        if (dmemWait)         state_d = DWAIT;
        else if (!imem_ready) state_d = IWAIT;
      end
      DWAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cntInc;
          if (cntInc == TimeoutVal) state_d = ERR;
        end
      end
      IWAIT: begin
        if (dmemWait) begin
          cnt_d   = cntInc;
          state_d = (cntInc == TimeoutVal) ? ERR : DWAIT;
        end else if (imem_ready) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cntInc;
          if (cntInc == TimeoutVal) state_d = ERR;
        end
      end
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Priority: ERR > DMEM wait > taken branch > load-use > IMEM wait.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    wait_err  = 1'b0;
    dmem_req  = 1'b0;
    if (!rst) begin
      dmem_req = mem_access && (state_q != ERR);
      if (state_q == ERR) begin
        {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
        wait_err = 1'b1;
      end else if (dmemWait) begin
        {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
      end else if (ex_br_taken) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
        stall_if = ~imem_ready;
      end else if (loadUse) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end else if (!imem_ready) begin
        stall_if = 1'b1;
        flush_id = 1'b1;
      end
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stallCnt_q, stallCnt_d;

  assign stallCnt_d = (stall_if && (stallCnt_q != 32'hFFFF_FFFF)) ?
                      stallCnt_q + 32'd1 : stallCnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stallCnt_q <= '0;
    else     stallCnt_q <= stallCnt_d;
  end

  assign stall_cycles = stallCnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (TIMEOUT=4); expected values are hand-computed.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, ex_is_load, ex_br_taken;
  logic        mem_access, dmem_ready, imem_ready;
  logic        stall_if, stall_id, stall_ex, stall_mem;
  logic        flush_id, flush_ex, dmem_req, wait_err;
  logic [31:0] stall_cycles;
  logic [7:0]  outs;

  int errors = 0;
  int checks = 0;

  // Packed view: {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, dmem_req, wait_err}
  assign outs = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, dmem_req, wait_err};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .mem_access(mem_access), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .dmem_req(dmem_req), .wait_err(wait_err),
    .stall_cycles(stall_cycles)
  );

  task automatic setIdle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rd = 5'd0; ex_is_load = 1'b0; ex_br_taken = 1'b0;
    mem_access = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
  endtask

  // Start a new cycle just after the clock edge with idle inputs; the caller
  // then overrides inputs and samples outputs on the falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    setIdle();
  endtask

  task automatic test_reset();
    setIdle();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    mem_access = 1'b1; dmem_ready = 1'b0; imem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 8'h00 || stall_cycles !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got outs=%b cnt=%0d, need outs=00000000 cnt=0", outs, stall_cycles);
    end
    applyStimulus();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_release_idle: got %b, need 00000000", outs);
    end
    // Reset asserted in the middle of a DMEM wait drops the request at once.
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      mem_access = 1'b1; dmem_ready = 1'b0;
      @(negedge clk);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_mid_wait: got %b, need 00000000", outs);
    end
    applyStimulus();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_mid_wait_release: got %b, need 00000000", outs);
    end
  endtask

  task automatic test_load_use();
    applyStimulus();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== 8'b1100_0100) begin
      errors++;
      $display("[TB] FAIL load_use_rs1: got %b, need 11000100", outs);
    end
    applyStimulus();
    id_rs1 = 5'd5; id_rs1_used = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== 8'h00) begin
      errors++;
      $display("[TB] FAIL load_use_bubble_done: got %b, need 00000000", outs);
    end
    applyStimulus();
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd3; id_rs1_used = 1'b1;
    id_rs2 = 5'd7; id_rs2_used = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== 8'b1100_0100) begin
      errors++;
      $display("[TB] FAIL load_use_rs2: got %b, need 11000100", outs);
    end
  endtask

  task automatic test_no_hazard();
    applyStimulus();
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    id_rs2 = 5'd0; id_rs2_used = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== 8'h00) begin
      errors++;
      $display("[TB] FAIL x0_not_hazard: got %b, need 00000000", outs);
    end
    applyStimulus();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd3; id_rs1_used = 1'b1;
    id_rs2 = 5'd5; id_rs2_used = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 8'h00) begin
      errors++;
      $display("[TB] FAIL rs2_unused: got %b, need 00000000", outs);
    end
    applyStimulus();
    ex_is_load = 1'b0; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== 8'h00) begin
      errors++;
      $display("[TB] FAIL non_load_match: got %b, need 00000000", outs);
    end
  endtask

  task automatic test_branch();
    applyStimulus();
    ex_br_taken = 1'b1;
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== 8'b0000_1100) begin
      errors++;
      $display("[TB] FAIL branch_over_load_use: got %b, need 00001100", outs);
    end
    applyStimulus();
    ex_br_taken = 1'b1; imem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 8'b1000_1100) begin
      errors++;
      $display("[TB] FAIL branch_imem_wait: got %b, need 10001100", outs);
    end
    applyStimulus();
    @(negedge clk);
    checks++;
    if (outs !== 8'h00) begin
      errors++;
      $display("[TB] FAIL branch_after_idle: got %b, need 00000000", outs);
    end
  endtask

  task automatic test_imem_wait();
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      imem_ready = 1'b0;
      if (i == 1) mem_access = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== ((i == 1) ? 8'b1000_1010 : 8'b1000_1000)) begin
        errors++;
        $display("[TB] FAIL imem_wait_cycle%0d: got %b, need %b", i, outs,
                 (i == 1) ? 8'b1000_1010 : 8'b1000_1000);
      end
    end
    applyStimulus();
    @(negedge clk);
    checks++;
    if (outs !== 8'h00) begin
      errors++;
      $display("[TB] FAIL imem_wait_release: got %b, need 00000000", outs);
    end
  endtask

  task automatic test_dmem_wait();
    // Taken branch sits frozen in EX during the wait, then flushes on release.
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      mem_access = 1'b1; dmem_ready = 1'b0; ex_br_taken = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== 8'b1111_0010) begin
        errors++;
        $display("[TB] FAIL dmem_wait_cycle%0d: got %b, need 11110010", i, outs);
      end
    end
    applyStimulus();
    mem_access = 1'b1; dmem_ready = 1'b1; ex_br_taken = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== 8'b0000_1110) begin
      errors++;
      $display("[TB] FAIL dmem_release_branch: got %b, need 00001110", outs);
    end
    applyStimulus();
    mem_access = 1'b1; dmem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== 8'b0000_0010) begin
      errors++;
      $display("[TB] FAIL dmem_ready_first_cycle: got %b, need 00000010", outs);
    end
    applyStimulus();
    @(negedge clk);
    checks++;
    if (outs !== 8'h00) begin
      errors++;
      $display("[TB] FAIL dmem_ready_no_dwait: got %b, need 00000000", outs);
    end
  endtask

  task automatic test_timeout();
    // RUN cycle plus four DWAIT cycles stall with the request up, then ERR.
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      mem_access = 1'b1; dmem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (outs !== 8'b1111_0010) begin
        errors++;
        $display("[TB] FAIL timeout_wait_cycle%0d: got %b, need 11110010", i, outs);
      end
    end
    applyStimulus();
    mem_access = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 8'b1111_0001) begin
      errors++;
      $display("[TB] FAIL timeout_err_entry: got %b, need 11110001", outs);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      @(negedge clk);
      checks++;
      if (outs !== 8'b1111_0001) begin
        errors++;
        $display("[TB] FAIL timeout_err_sticky%0d: got %b, need 11110001", i, outs);
      end
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== 8'h00) begin
      errors++;
      $display("[TB] FAIL timeout_rst_clear: got %b, need 00000000", outs);
    end
    applyStimulus();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 8'h00) begin
      errors++;
      $display("[TB] FAIL timeout_after_rst: got %b, need 00000000", outs);
    end
  endtask

  task automatic test_stall_count();
    logic [31:0] expCnt;
`ifdef PIPE_STALL_CNT_EN
    expCnt = 32'd5;
`else
    expCnt = 32'd0;
`endif
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      ex_is_load = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_rs2_used = 1'b1;
      applyStimulus();
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      imem_ready = 1'b0;
    end
    applyStimulus();
    @(negedge clk);
    checks++;
    if (stall_cycles !== expCnt) begin
      errors++;
      $display("[TB] FAIL stall_cycles: got %0d, need %0d", stall_cycles, expCnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_imem_wait();
    test_dmem_wait();
    test_timeout();
    test_stall_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
